// File: rtl/player_move_ctrl_if.sv
// Move-request handshake between the game logic (master) and the player
// movement sequencer (slave).
interface player_move_ctrl_if;
    logic       move_valid;
    logic [2:0] move_steps;
    logic       move_ready;

    modport master (
        output move_valid,
        output move_steps,
        input  move_ready
    );

    modport slave (
        input  move_valid,
        input  move_steps,
        output move_ready
    );
endinterface

// File: rtl/player_move_ctrl.sv
// Player sprite movement sequencer: accepts dice-roll moves and walks the
// sprite tile by tile with a frame-paced hop, updating position only on frame ticks.
module player_move_ctrl #(
    parameter int BASE_X       = 16,
    parameter int BASE_Y       = 124,
    parameter int TILE_W       = 32,
    parameter int NUM_TILES    = 16,
    parameter int SPEED        = 2,
    parameter int PAUSE_FRAMES = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         frame_tick,
    player_move_ctrl_if.slave            move_if,
    output logic [9:0]                   player_x,
    output logic [9:0]                   player_y,
    output logic [$clog2(NUM_TILES)-1:0] tile_idx,
    output logic                         busy,
    output logic                         move_done,
    output logic                         lap
);
    localparam int STEP_FRAMES = TILE_W / SPEED;
    localparam int HALF        = STEP_FRAMES / 2;
    localparam int TW          = $clog2(NUM_TILES);
    localparam int KW          = $clog2(STEP_FRAMES + 1);
    localparam int PW          = $clog2(PAUSE_FRAMES + 1);

    localparam logic [KW-1:0] K_LAST    = KW'(STEP_FRAMES - 1);
    localparam logic [KW-1:0] K_HALF    = KW'(HALF);
    localparam logic [PW-1:0] P_LAST    = PW'(PAUSE_FRAMES - 1);
    localparam logic [TW-1:0] TILE_LAST = TW'(NUM_TILES - 1);

    // Parameter sanity checks at elaboration time.
    if (TILE_W % (2 * SPEED) != 0) begin : g_bad_pitch
        $error("TILE_W must be a multiple of 2*SPEED");
    end
    if (PAUSE_FRAMES < 1) begin : g_bad_pause
        $error("PAUSE_FRAMES must be at least 1");
    end
    if (NUM_TILES < 2) begin : g_bad_tiles
        $error("NUM_TILES must be at least 2");
    end
    if (BASE_X + TILE_W * (NUM_TILES - 1) >= 640) begin : g_bad_x
        $error("player_x would leave the 640-pixel screen");
    end
    if (BASE_Y < HALF) begin : g_bad_y
        $error("hop peak would drive player_y negative");
    end

    typedef enum logic [1:0] {IDLE, HOP, LAND} state_t;

    state_t        state_reg, state_next;
    logic [KW-1:0] k_reg, k_next;
    logic [2:0]    steps_left_reg, steps_left_next;
    logic [PW-1:0] land_reg, land_next;
    logic [9:0]    x_reg, x_next;
    logic [9:0]    y_reg, y_next;
    logic [TW-1:0] tile_reg, tile_next;
    logic          busy_reg, busy_next;
    logic          ready_reg, ready_next;
    logic          done_reg, done_next;
    logic          lap_reg, lap_next;

    logic          accept;
    logic [2:0]    steps_sat;
    logic          step_end;
    logic          land_end;
    logic          wrap_step;
    logic [KW-1:0] k_inc;
    logic [9:0]    hop_px;

    assign accept    = ready_reg && move_if.move_valid;
    assign steps_sat = (move_if.move_steps == 3'd7) ? 3'd6 : move_if.move_steps;
    assign step_end  = frame_tick && (k_reg == K_LAST);
    assign land_end  = frame_tick && (land_reg == P_LAST);
    assign wrap_step = (tile_reg == TILE_LAST);
    assign k_inc     = k_reg + KW'(1);
    // Triangular hop profile: rises one pixel per frame, then falls back.
    assign hop_px    = (k_inc <= K_HALF) ? 10'(k_inc) : 10'(STEP_FRAMES) - 10'(k_inc);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg      <= IDLE;
            k_reg          <= '0;
            steps_left_reg <= '0;
            land_reg       <= '0;
            x_reg          <= 10'(BASE_X);
            y_reg          <= 10'(BASE_Y);
            tile_reg       <= '0;
            busy_reg       <= 1'b0;
            ready_reg      <= 1'b1;
            done_reg       <= 1'b0;
            lap_reg        <= 1'b0;
        end else begin
            state_reg      <= state_next;
            k_reg          <= k_next;
            steps_left_reg <= steps_left_next;
            land_reg       <= land_next;
            x_reg          <= x_next;
            y_reg          <= y_next;
            tile_reg       <= tile_next;
            busy_reg       <= busy_next;
            ready_reg      <= ready_next;
            done_reg       <= done_next;
            lap_reg        <= lap_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (accept && steps_sat != 3'd0) state_next = HOP;
            HOP:  if (step_end && steps_left_reg == 3'd1) state_next = LAND;
            LAND: if (land_end) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        k_next          = k_reg;
        steps_left_next = steps_left_reg;
        land_next       = land_reg;
        x_next          = x_reg;
        y_next          = y_reg;
        tile_next       = tile_reg;
        done_next       = 1'b0;
        lap_next        = 1'b0;
        busy_next       = (state_next != IDLE);
        ready_next      = (state_next == IDLE);
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    if (steps_sat == 3'd0) begin
                        done_next = 1'b1;
                    end else begin
                        steps_left_next = steps_sat;
                        k_next          = '0;
                        land_next       = '0;
                    end
                end
            end
            HOP: begin
                if (step_end) begin
                    k_next          = '0;
                    y_next          = 10'(BASE_Y);
                    steps_left_next = steps_left_reg - 3'd1;
                    land_next       = '0;
                    if (wrap_step) begin
                        tile_next = '0;
                        x_next    = 10'(BASE_X);
                        lap_next  = 1'b1;
                    end else begin
                        tile_next = tile_reg + TW'(1);
                        x_next    = x_reg + 10'(SPEED);
                    end
                end else if (frame_tick) begin
                    k_next = k_inc;
                    y_next = 10'(BASE_Y) - hop_px;
                    // The wrap hop stays in place; x snaps back to tile 0 on landing.
                    if (!wrap_step) x_next = x_reg + 10'(SPEED);
                end
            end
            LAND: begin
                if (land_end) begin
                    land_next = '0;
                    done_next = 1'b1;
                end else if (frame_tick) begin
                    land_next = land_reg + PW'(1);
                end
            end
            default: ;
        endcase
    end

    assign player_x           = x_reg;
    assign player_y           = y_reg;
    assign tile_idx           = tile_reg;
    assign busy               = busy_reg;
    assign move_done          = done_reg;
    assign lap                = lap_reg;
    assign move_if.move_ready = ready_reg;
endmodule

// File: tb/tb_player_move_ctrl.sv
// Randomized bench for player_move_ctrl against a closed-form position model
// driven by ticks elapsed since the accepted move.
module tb_player_move_ctrl;
    localparam int BASE_X       = 16;
    localparam int BASE_Y       = 124;
    localparam int TILE_W       = 32;
    localparam int NUM_TILES    = 16;
    localparam int SPEED        = 2;
    localparam int PAUSE_FRAMES = 4;
    localparam int SF           = TILE_W / SPEED;
    localparam int HALF         = SF / 2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       frame_tick = 1'b0;
    logic [9:0] player_x, player_y;
    logic [3:0] tile_idx;
    logic       busy, move_done, lap;

    player_move_ctrl_if mv();

    always #5 clk = ~clk;

    player_move_ctrl #(
        .BASE_X(BASE_X), .BASE_Y(BASE_Y), .TILE_W(TILE_W),
        .NUM_TILES(NUM_TILES), .SPEED(SPEED), .PAUSE_FRAMES(PAUSE_FRAMES)
    ) dut (
        .clk(clk), .reset(reset), .frame_tick(frame_tick), .move_if(mv),
        .player_x(player_x), .player_y(player_y), .tile_idx(tile_idx),
        .busy(busy), .move_done(move_done), .lap(lap)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: a move is fully described by its start tile, step
    // count and the number of frame ticks seen since acceptance.
    bit m_active;
    int m_t0, m_n, m_ticks, m_tile;
    bit exp_done, exp_lap;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_active = 0; m_t0 = 0; m_n = 0; m_ticks = 0; m_tile = 0;
        exp_done = 0; exp_lap = 0;
    endtask

    task automatic model_edge(input bit tick, input bit valid, input int steps);
        int s;
        int done_step;
        exp_done = 0;
        exp_lap  = 0;
        if (!m_active) begin
            if (valid) begin
                s = (steps == 7) ? 6 : steps;
                if (s == 0) exp_done = 1;
                else begin
                    m_active = 1; m_t0 = m_tile; m_n = s; m_ticks = 0;
                end
            end
        end else if (tick) begin
            m_ticks++;
            if (m_ticks <= m_n * SF && m_ticks % SF == 0) begin
                done_step = m_ticks / SF - 1;
                if ((m_t0 + done_step) % NUM_TILES == NUM_TILES - 1) exp_lap = 1;
            end
            if (m_ticks == m_n * SF + PAUSE_FRAMES) begin
                exp_done = 1;
                m_active = 0;
                m_tile   = (m_t0 + m_n) % NUM_TILES;
            end
        end
    endtask

    task automatic check_outputs();
        int tile, x, y, kk;
        if (!m_active) begin
            tile = m_tile;
            x    = BASE_X + TILE_W * tile;
            y    = BASE_Y;
        end else if (m_ticks < m_n * SF) begin
            tile = (m_t0 + m_ticks / SF) % NUM_TILES;
            kk   = m_ticks % SF;
            x    = (tile == NUM_TILES - 1) ? BASE_X + TILE_W * tile
                                           : BASE_X + TILE_W * tile + SPEED * kk;
            y    = BASE_Y - ((kk <= HALF) ? kk : SF - kk);
        end else begin
            tile = (m_t0 + m_n) % NUM_TILES;
            x    = BASE_X + TILE_W * tile;
            y    = BASE_Y;
        end
        check("player_x", int'(player_x), x);
        check("player_y", int'(player_y), y);
        check("tile_idx", int'(tile_idx), tile);
        check("busy", int'(busy), int'(m_active));
        check("move_ready", int'(mv.move_ready), int'(!m_active));
        check("move_done", int'(move_done), int'(exp_done));
        check("lap", int'(lap), int'(exp_lap));
    endtask

    task automatic run_cycle(input bit tick, input bit valid, input int steps);
        frame_tick    = tick;
        mv.move_valid = valid;
        mv.move_steps = 3'(steps);
        @(posedge clk);
        model_edge(tick, valid, steps);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (m_active && n < 600) begin
            run_cycle(1, 0, 0);
            n++;
        end
        check("idle_timeout", int'(m_active), 0);
    endtask

    initial begin
        mv.move_valid = 1'b0;
        mv.move_steps = 3'd0;
        model_reset();
        @(negedge clk);
        check_outputs();
        reset = 1'b0;

        // Single step with a tick every cycle, then steps=3 accepted on a tick
        // with move_valid held through the move (back-to-back on move_done).
        run_cycle(0, 1, 1);
        for (int i = 0; i < 22; i++) run_cycle(1, 0, 0);
        run_cycle(1, 1, 3);
        for (int i = 0; i < 60; i++) run_cycle(1, 1, 2);
        wait_idle();
        run_cycle(1, 1, 0);
        run_cycle(0, 0, 0);
        run_cycle(0, 1, 7);
        wait_idle();

        for (int i = 0; i < 5000; i++)
            run_cycle($urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0,
                      int'($urandom_range(0, 7)));
        wait_idle();

        // Asynchronous reset at k=5 of the second step of a move.
        run_cycle(0, 1, 3);
        for (int i = 0; i < 200; i++) begin
            if (m_active && m_ticks == SF + 5) break;
            run_cycle(1, 0, 0);
        end
        check("reach_mid_hop", int'(m_active && m_ticks == SF + 5), 1);
        reset = 1'b1;
        #1;
        model_reset();
        check_outputs();
        run_cycle(1, 0, 0);
        reset = 1'b0;
        for (int i = 0; i < 30; i++) run_cycle(1, 0, 0);
        run_cycle(1, 1, 2);
        wait_idle();
        run_cycle(0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
